debug_controller: RTL
=====================

// Module: debug_controller
// PURPOSE
//   UART-driven run/step/dump sequencer for the 5-stage MIPS pipeline.
//   - Decodes command bytes from the UART receiver.
//   - Gates the pipeline clock-enable: stall of PC plus all stage latches.
//   - Counts executed cycles.
//   - Streams a snapshot frame back through the UART transmitter:
//     PC, cycle count, then the register file read through a debug port.
// PARAMETERS
//   CYCLE_W   32     width of executed-cycle counter (8..32)
//   NUM_REGS  32     registers dumped, addresses 0..NUM_REGS-1 (1..32)
//   CMD_RUN   8'h63  'c' continuous run
//   CMD_STEP  8'h73  's' single step
//   CMD_HALT  8'h68  'h' halt
//   CMD_DUMP  8'h64  'd' dump snapshot
// PORTS
//   clk           in   1    system clock, all state on rising edge
//   reset         in   1    asynchronous, active-low; clears all state
//   rx_data       in   8    received byte
//   rx_valid      in   1    one-cycle pulse: rx_data valid
//   tx_busy       in   1    transmitter shifting a byte
//   tx_data       out  8    byte to send; held stable from tx_start until tx_busy falls
//   tx_start      out  1    one-cycle pulse: load tx_data into transmitter
//   halt_in       in   1    level: pipeline has retired a HALT instruction
//   pc_in         in   32   current fetch PC
//   dbg_reg_addr  out  5    register-file debug read address
//   dbg_reg_data  in   32   combinational read data for dbg_reg_addr
//   pipe_en       out  1    registered pipeline enable; 1 = advance one cycle
//   running       out  1    1 while in RUN
// BEHAVIOUR
//   Reset values: pipe_en=0, running=0, tx_start=0, tx_data=0, dbg_reg_addr=0,
//   cycle_cnt=0, state=IDLE. Reset asserted mid-operation aborts immediately;
//   no partial byte is completed.
//   States: IDLE, RUN, STEP, TX_LOAD, TX_WAIT.
//   - IDLE:
//     - rx_valid & CMD_RUN & !halt_in -> RUN.
//     - rx_valid & CMD_STEP & !halt_in -> STEP.
//     - rx_valid & CMD_DUMP -> TX_LOAD: snapshot pc_in and cycle_cnt, byte index 0.
//     - Any other byte, and RUN/STEP while halt_in=1, is ignored.
//   - STEP: pipe_en=1 for exactly one cycle, then IDLE.
//   - RUN: pipe_en=1, running=1 every cycle.
//     - Exit to IDLE on rx_valid & CMD_HALT, or on halt_in=1; both together -> IDLE.
//     - pipe_en is low in the cycle after exit.
//     - CMD_DUMP/RUN/STEP received in RUN are ignored.
//   - Latency: pipe_en rises the cycle after the accepting rx_valid
//     and falls the cycle after the exit event.
//   - cycle_cnt increments by 1 in every cycle with pipe_en=1.
//     It wraps modulo 2^CYCLE_W unless CYCLE_SAT_EN is defined.
//   - Dump frame, N = 9 + 4*NUM_REGS bytes, multi-byte fields LSB first:
//     8'hA5, PC[4], cycle_cnt[4] (zero-extended to 32 b), reg0[4] .. reg(NUM_REGS-1)[4].
//   - TX_LOAD: when tx_busy=0, drive tx_data, pulse tx_start, go to TX_WAIT.
//   - TX_WAIT: ignore tx_busy in the first cycle after tx_start, then wait for
//     tx_busy=0. Advance the index; last byte -> IDLE, else TX_LOAD.
//   - tx_start never asserts while tx_busy=1.
//   - dbg_reg_addr = index of the register being sent, updated at each reg
//     boundary. Register bytes are taken from dbg_reg_data live (not snapshotted).
//   - All rx bytes are ignored during a dump. pipe_en=0 throughout the dump.
// CONFIGURATION
//   CYCLE_SAT_EN defined: cycle_cnt saturates at 2^CYCLE_W-1.
//   CYCLE_SAT_EN undefined: cycle_cnt wraps to 0.
// TESTING
//   1. Reset, rx 's' -> pipe_en=1 for exactly 1 cycle, 1 cycle after rx_valid;
//      then dump shows cycle_cnt=1.
//   2. rx 'c' at cycle 0, rx 'h' at cycle 10 -> pipe_en=1 cycles 1..10, 0 from 11;
//      running mirrors pipe_en; cycle_cnt=10.
//   3. In RUN, raise halt_in -> pipe_en=0 next cycle; later 'c' and 's' both
//      ignored while halt_in=1.
//   4. pc_in=32'h40, cycle_cnt=3, reg[i]=i, NUM_REGS=32, rx 'd' -> 137 bytes:
//      A5 40 00 00 00 03 00 00 00 00 00 00 00 01 00 00 00 ... 1F 00 00 00;
//      tx_start never while tx_busy=1.
//   5. Assert reset at byte 20 of a dump -> tx_start=0, IDLE; next 'd' restarts at A5.
//   6. CYCLE_W=8, run 300 cycles -> cycle_cnt=255 with CYCLE_SAT_EN, 44 without.

Source files
------------

// File: rtl/debug_controller.sv
// UART-driven run/step/dump sequencer for the 5-stage MIPS pipeline.
// Optional macro CYCLE_SAT_EN: cycle counter saturates instead of wrapping.
module debug_controller #(
    parameter int         CYCLE_W  = 32,
    parameter int         NUM_REGS = 32,
    parameter logic [7:0] CMD_RUN  = 8'h63,
    parameter logic [7:0] CMD_STEP = 8'h73,
    parameter logic [7:0] CMD_HALT = 8'h68,
    parameter logic [7:0] CMD_DUMP = 8'h64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_tx_busy,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_start,
    input  logic        i_halt_in,
    input  logic [31:0] i_pc_in,
    output logic [4:0]  o_dbg_reg_addr,
    input  logic [31:0] i_dbg_reg_data,
    output logic        o_pipe_en,
    output logic        o_running,
    output logic [2:0]  o_state
);

    // Handshake: o_tx_start is a one-cycle pulse issued only when i_tx_busy=0;
    // o_tx_data stays put until the next load. i_rx_valid is a one-cycle strobe.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_STEP    = 3'd2,
        S_TX_LOAD = 3'd3,
        S_TX_WAIT = 3'd4
    } state_t;

    localparam int                 FRAME_LEN = 9 + 4 * NUM_REGS;
    localparam logic [7:0]         LAST_IDX  = 8'(FRAME_LEN - 1);
    localparam logic [CYCLE_W-1:0] CNT_MAX   = '1;

    state_t             r_state;
    logic               r_pipe_en;
    logic               r_running;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic [4:0]         r_dbg_reg_addr;
    logic [CYCLE_W-1:0] r_cycle_cnt;
    logic [31:0]        r_pc_snap;
    logic [31:0]        r_cnt_snap;
    logic [7:0]         r_idx;
    logic [1:0]         r_guard;

    logic [CYCLE_W-1:0] w_cnt_next;
    logic [7:0]         w_idx_m1;
    logic [7:0]         w_next_idx;
    logic [7:0]         w_next_off;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;

    // Every field after the header byte is a 32-bit word sent LSB first,
    // so the byte lane is simply (index-1) mod 4.
    always_comb begin
        w_idx_m1   = r_idx - 8'd1;
        w_next_idx = r_idx + 8'd1;
        w_next_off = w_next_idx - 8'd9;
        w_word     = i_dbg_reg_data;
        if (r_idx < 8'd5) begin
            w_word = r_pc_snap;
        end else if (r_idx < 8'd9) begin
            w_word = r_cnt_snap;
        end
        case (w_idx_m1[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        if (r_idx == 8'd0) begin
            w_byte = 8'hA5;
        end
    end

`ifdef CYCLE_SAT_EN
    assign w_cnt_next = (r_cycle_cnt == CNT_MAX) ? r_cycle_cnt : r_cycle_cnt + 1'b1;
`else
    assign w_cnt_next = r_cycle_cnt + 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle_cnt <= '0;
        end else if (r_pipe_en) begin
            r_cycle_cnt <= w_cnt_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_pipe_en      <= 1'b0;
            r_running      <= 1'b0;
            r_tx_start     <= 1'b0;
            r_tx_data      <= 8'h00;
            r_dbg_reg_addr <= 5'd0;
            r_pc_snap      <= 32'h0;
            r_cnt_snap     <= 32'h0;
            r_idx          <= 8'd0;
            r_guard        <= 2'd0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_rx_valid) begin
                        if ((i_rx_data == CMD_RUN) && !i_halt_in) begin
                            r_state   <= S_RUN;
                            r_pipe_en <= 1'b1;
                            r_running <= 1'b1;
                        end else if ((i_rx_data == CMD_STEP) && !i_halt_in) begin
                            r_state   <= S_STEP;
                            r_pipe_en <= 1'b1;
                        end else if (i_rx_data == CMD_DUMP) begin
                            r_state        <= S_TX_LOAD;
                            r_pc_snap      <= i_pc_in;
                            r_cnt_snap     <= 32'(r_cycle_cnt);
                            r_idx          <= 8'd0;
                            r_dbg_reg_addr <= 5'd0;
                        end
                    end
                end
                S_RUN: begin
                    if ((i_rx_valid && (i_rx_data == CMD_HALT)) || i_halt_in) begin
                        r_state   <= S_IDLE;
                        r_pipe_en <= 1'b0;
                        r_running <= 1'b0;
                    end
                end
                S_STEP: begin
                    r_state   <= S_IDLE;
                    r_pipe_en <= 1'b0;
                end
                S_TX_LOAD: begin
                    if (!i_tx_busy) begin
                        r_tx_data  <= w_byte;
                        r_tx_start <= 1'b1;
                        r_guard    <= 2'd2;
                        r_state    <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    // Busy is blind for the pulse cycle and the one after it.
                    if (r_guard != 2'd0) begin
                        r_guard <= r_guard - 2'd1;
                    end else if (!i_tx_busy) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_state <= S_TX_LOAD;
                            if (w_next_idx >= 8'd9) begin
                                r_dbg_reg_addr <= w_next_off[6:2];
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_pipe_en      = r_pipe_en;
    assign o_running      = r_running;
    assign o_tx_start     = r_tx_start;
    assign o_tx_data      = r_tx_data;
    assign o_dbg_reg_addr = r_dbg_reg_addr;
    assign o_state        = r_state;

endmodule
